// File: rtl/cls_recovery_ctrl.sv
// Lockstep-core recovery controller: pulses the shared core reset on each accepted
// fault and escalates to a permanent halt after MAX_FAULTS recent faults.
// Define CLS_RECOVERY_WINDOW_EN to build the fault-free window that decays the recent count.
module cls_recovery_ctrl #(
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned MAX_FAULTS = 3,
    parameter int unsigned WINDOW     = 1024
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        fault_i,
    input  logic        clr_i,
    output logic        core_rst_no,
    output logic        trg_o,
    output logic        halt_o,
    input  logic        stat_req_i,
    input  logic [1:0]  stat_addr_i,
    output logic [31:0] stat_rdata_o,
    output logic        stat_valid_o,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        SETTLE = 2'b01,
        RUN    = 2'b10,
        HALT   = 2'b11
    } state_t;

    localparam logic [7:0]  HOLD_LOAD = 8'(RST_CYCLES - 1);
    localparam logic [7:0]  MAX_F     = 8'(MAX_FAULTS);
    localparam logic [31:0] ID_WORD   = 32'h434C_5301;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  hold_cnt_q;
    logic [7:0]  recent_q;
    logic [7:0]  recent_d;
    logic [15:0] total_q;
    logic [15:0] total_d;
    logic [31:0] since_q;
    logic        fault_acc;
    logic        decay;
    logic [31:0] stat_word;

    // A fault is only meaningful while the cores are actually running.
    assign fault_acc = (state_q == RUN) && fault_i;

`ifdef CLS_RECOVERY_WINDOW_EN
    localparam logic [16:0] WIN_LAST = 17'(WINDOW - 1);
    logic [16:0] win_q;

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            win_q <= '0;
        end else if (clr_i || fault_acc) begin
            win_q <= '0;
        end else if (state_q == RUN) begin
            if (win_q == WIN_LAST) begin
                win_q <= '0;
            end else begin
                win_q <= win_q + 17'd1;
            end
        end
    end

    assign decay = (state_q == RUN) && !clr_i && !fault_acc && (win_q == WIN_LAST);
`else
    logic unused_window;
    assign unused_window = (WINDOW > 1);
    assign decay         = 1'b0;
`endif

    // Clear is applied before the increment so a coincident fault counts as the first.
    always_comb begin
        recent_d = recent_q;
        total_d  = total_q;
        if (clr_i) begin
            recent_d = '0;
            total_d  = '0;
        end
        if (decay) begin
            recent_d = '0;
        end
        if (fault_acc) begin
            if (recent_d != 8'hFF) begin
                recent_d = recent_d + 8'd1;
            end
            if (total_d != 16'hFFFF) begin
                total_d = total_d + 16'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HOLD:    if (hold_cnt_q == 8'd0) state_d = SETTLE;
            SETTLE:  state_d = RUN;
            RUN:     if (fault_acc) state_d = (recent_d >= MAX_F) ? HALT : HOLD;
            HALT:    if (clr_i) state_d = HOLD;
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= HOLD;
            recent_q <= '0;
            total_q  <= '0;
            trg_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            recent_q <= recent_d;
            total_q  <= total_d;
            trg_o    <= fault_acc;
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            hold_cnt_q <= HOLD_LOAD;
        end else if ((state_d == HOLD) && (state_q != HOLD)) begin
            hold_cnt_q <= HOLD_LOAD;
        end else if ((state_q == HOLD) && (hold_cnt_q != 8'd0)) begin
            hold_cnt_q <= hold_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            since_q <= '0;
        end else if ((state_d == SETTLE) && (state_q != SETTLE)) begin
            since_q <= '0;
        end else if ((state_q == RUN) && (since_q != 32'hFFFF_FFFF)) begin
            since_q <= since_q + 32'd1;
        end
    end

    always_comb begin
        core_rst_no = (state_q == SETTLE) || (state_q == RUN);
        halt_o      = (state_q == HALT);
        dbg_state_o = state_q;
    end

    // Status port: stat_req_i is a one-cycle strobe with no back-pressure; every strobe
    // gets stat_valid_o exactly one cycle later, and rdata is zero whenever valid is low.
    always_comb begin
        unique case (stat_addr_i)
            2'd0:    stat_word = {21'b0, halt_o, state_q, recent_q};
            2'd1:    stat_word = {16'b0, total_q};
            2'd2:    stat_word = since_q;
            default: stat_word = ID_WORD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            stat_valid_o <= 1'b0;
            stat_rdata_o <= '0;
        end else begin
            stat_valid_o <= stat_req_i;
            stat_rdata_o <= stat_req_i ? stat_word : 32'd0;
        end
    end

endmodule
